baud_tick_gen_prog: RTL

Programmable baud tick generator for the UART datapath. It replaces the fixed mod-M tick source with a runtime-loadable divisor, and produces two outputs: an oversampling tick for the receiver and a derived bit tick (one per OVERSAMPLE sample ticks) for the transmitter. It sits between the system clock and the UART RX/TX FSMs. It also supports enable/hold, rejection of illegal divisors and, optionally, counter resynchronisation.

---
 rtl/baud_tick_gen_prog.sv | 101 ++++++++++
 1 files changed

// File: rtl/baud_tick_gen_prog.sv
// baud_tick_gen_prog: programmable baud tick generator.
// A runtime-loadable divisor produces a one-cycle oversampling tick
// (o_sample_tick). A second counter produces a bit tick (o_bit_tick)
// once every OVERSAMPLE sample ticks.
// Optional feature macro: BAUD_RESYNC_EN. When it is defined, i_resync
// restarts both counters. When it is undefined, i_resync is ignored.
module baud_tick_gen_prog #(
   parameter int N           = 8,
   parameter int DEFAULT_DIV = 163,
   parameter int OVERSAMPLE  = 16,
   parameter int OS_W        = $clog2(OVERSAMPLE)
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_enable,
   input  logic [N-1:0] i_div,
   input  logic         i_div_load,
   input  logic         i_resync,
   output logic [N-1:0] o_div,
   output logic         o_div_err,
   output logic         o_sample_tick,
   output logic         o_bit_tick
);

   localparam logic [N-1:0]    DEF_DIV = N'(DEFAULT_DIV);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

   logic [N-1:0]    div_reg, div_nxt;
   logic [N-1:0]    cnt, cnt_nxt;
   logic [OS_W-1:0] os_cnt, os_nxt;
   logic            sample_nxt, bit_nxt, err_nxt;
   logic            resync_act;

`ifdef BAUD_RESYNC_EN
   assign resync_act = i_resync;
`else
   // The port is kept so that both builds have the same interface.
   logic unused_resync;
   assign unused_resync = i_resync;
   assign resync_act    = 1'b0;
`endif

   assign o_div = div_reg;

   // Next-state logic, priority: load > resync > count > hold
   always_comb begin
      div_nxt    = div_reg;
      cnt_nxt    = cnt;
      os_nxt     = os_cnt;
      sample_nxt = 1'b0;
      bit_nxt    = 1'b0;
      err_nxt    = 1'b0;
      if (i_div_load) begin
         if (i_div != '0) begin
            div_nxt = i_div;
            cnt_nxt = '0;
            os_nxt  = '0;
         end else begin
            // A divisor of 0 is rejected and all state is left untouched.
            err_nxt = 1'b1;
         end
      end else if (resync_act) begin
         cnt_nxt = '0;
         os_nxt  = '0;
      end else if (i_enable) begin
         // div_reg is never 0, so div_reg-1 cannot wrap.
         if (cnt == div_reg - 1'b1) begin
            cnt_nxt    = '0;
            sample_nxt = 1'b1;
            if (os_cnt == OS_LAST) begin
               os_nxt  = '0;
               bit_nxt = 1'b1;
            end else begin
               os_nxt = os_cnt + 1'b1;
            end
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
   end

   // State and registered outputs, synchronous active-high reset
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         div_reg       <= DEF_DIV;
         cnt           <= '0;
         os_cnt        <= '0;
         o_sample_tick <= 1'b0;
         o_bit_tick    <= 1'b0;
         o_div_err     <= 1'b0;
      end else begin
         div_reg       <= div_nxt;
         cnt           <= cnt_nxt;
         os_cnt        <= os_nxt;
         o_sample_tick <= sample_nxt;
         o_bit_tick    <= bit_nxt;
         o_div_err     <= err_nxt;
      end
   end

endmodule
